sram_access_ctrl: RTL and testbench

Command-driven initiator for the single-port SRAM. It accepts read and write commands over a valid/ready interface and drives the SRAM's `data_wren`, `data_rden`, `addr_in`, `addr_out` and `data_in` pins. Read data comes back on a backpressured response port. A per-address written-bitmap flags reads of locations that have never been written. It sits between the datapath logic and the SRAM instance.

---
 rtl/sram_access_ctrl_if.sv | 51 +++++
 rtl/sram_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Command/response handshake and SRAM pin bundle for sram_access_ctrl.
// Ports: cmd_* (request in), rsp_* (read response out), clear_valid, busy,
//        SRAM pins data_wren/data_rden/addr_in/addr_out/data_in/data_out.
// slave = the controller's view; master = requester plus SRAM instance view.
interface sram_access_ctrl_if #(
  parameter int DATA_SIZE       = 16,
  parameter int SRAM_DEPTH_LOG2 = 5
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [SRAM_DEPTH_LOG2-1:0] cmd_addr;
  logic [DATA_SIZE-1:0]       cmd_wdata;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_SIZE-1:0]       rsp_rdata;
  logic                       rsp_err;

  logic                       clear_valid;
  logic                       busy;

  logic                       data_wren;
  logic                       data_rden;
  logic [SRAM_DEPTH_LOG2-1:0] addr_in;
  logic [SRAM_DEPTH_LOG2-1:0] addr_out;
  logic [DATA_SIZE-1:0]       data_in;
  logic [DATA_SIZE-1:0]       data_out;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    input  clear_valid,
    output busy,
    output data_wren, data_rden, addr_in, addr_out, data_in,
    input  data_out
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    output clear_valid,
    input  busy,
    input  data_wren, data_rden, addr_in, addr_out, data_in,
    output data_out
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Single-outstanding read/write initiator for a single-port SRAM, with a
// per-address written-bitmap that flags reads of never-written locations.
// Ports: clock, reset (sync, active-high), bus (sram_access_ctrl_if.slave).
// Latency: write strobe 1 cycle after handshake; read response valid
// 2+READ_LATENCY cycles after handshake. Response held stable under
// backpressure; no new command accepted until the response is consumed.
module sram_access_ctrl #(
  parameter int DATA_SIZE       = 16,
  parameter int SRAM_DEPTH_LOG2 = 5,
  parameter int READ_LATENCY    = 1   // 1..4
) (
  input  logic              clock,
  input  logic              reset,
  sram_access_ctrl_if.slave bus
);

  localparam int SRAM_DEPTH = 1 << SRAM_DEPTH_LOG2;
  // Counter counts down from READ_LATENCY-1; 2 bits covers the 1..4 range.
  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                     state_q;
  logic                       is_write_q;
  logic [SRAM_DEPTH_LOG2-1:0] addr_q;
  logic [1:0]                 lat_cnt_q;
  logic [SRAM_DEPTH-1:0]      bitmap_q;
  logic [SRAM_DEPTH-1:0]      bitmap_d;
  logic                       busy_q;
  logic                       wren_q;
  logic                       rden_q;
  logic [SRAM_DEPTH_LOG2-1:0] addr_in_q;
  logic [SRAM_DEPTH_LOG2-1:0] addr_out_q;
  logic [DATA_SIZE-1:0]       data_in_q;
  logic                       rsp_valid_q;
  logic [DATA_SIZE-1:0]       rsp_rdata_q;
  logic                       rsp_err_q;

  logic cmd_ready;
  logic cmd_hs;

  // Ready is gated by reset so nothing is accepted while reset is asserted,
  // and it rises in the first cycle after reset drops.
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign cmd_hs    = bus.cmd_valid && cmd_ready;

  // Clear first, then the ISSUE write sets its bit, so a coincident write wins.
  // A read in ISSUE samples bitmap_q, i.e. the pre-clear value.
  always_comb begin
    bitmap_d = bitmap_q;
    if (bus.clear_valid) begin
      bitmap_d = '0;
    end
    if (state_q == ISSUE && is_write_q) begin
      bitmap_d[addr_q] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      lat_cnt_q   <= '0;
      bitmap_q    <= '0;
      busy_q      <= 1'b0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      addr_in_q   <= '0;
      addr_out_q  <= '0;
      data_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      // Strobes are single-cycle pulses; only the IDLE handshake raises them.
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            is_write_q <= bus.cmd_write;
            addr_q     <= bus.cmd_addr;
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            // Strobe and pins are registered at the handshake so they are
            // driven during ISSUE; the unused-direction pins keep their values.
            if (bus.cmd_write) begin
              wren_q    <= 1'b1;
              addr_in_q <= bus.cmd_addr;
              data_in_q <= bus.cmd_wdata;
            end else begin
              rden_q     <= 1'b1;
              addr_out_q <= bus.cmd_addr;
            end
          end
        end

        ISSUE: begin
          if (is_write_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            rsp_err_q <= ~bitmap_q[addr_q];
            lat_cnt_q <= LAT_INIT;
            state_q   <= RDWAIT;
          end
        end

        RDWAIT: begin
          if (lat_cnt_q == 2'd0) begin
            rsp_rdata_q <= bus.data_out;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 2'd1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
  assign bus.data_wren = wren_q;
  assign bus.data_rden = rden_q;
  assign bus.addr_in   = addr_in_q;
  assign bus.addr_out  = addr_out_q;
  assign bus.data_in   = data_in_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: behavioural SRAM (READ_LATENCY=1), reference
// memory/bitmap model, and a scoreboard queue of expected read responses.
// Inputs driven #1 after posedge; outputs sampled on negedge.
module tb_sram_access_ctrl;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_access_ctrl_if #(.DATA_SIZE(16), .SRAM_DEPTH_LOG2(5)) bus ();

  sram_access_ctrl #(
    .DATA_SIZE(16),
    .SRAM_DEPTH_LOG2(5),
    .READ_LATENCY(1)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  // Behavioural single-port SRAM, one cycle read latency.
  logic [15:0] sram_mem [32] = '{default: 16'h0};
  always @(posedge clk) begin
    if (bus.data_wren) sram_mem[bus.addr_in] <= bus.data_in;
    if (bus.data_rden) bus.data_out <= sram_mem[bus.addr_out];
  end

  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  logic [15:0] model_mem [32];
  logic [31:0] written;
  logic [4:0]  last_waddr;
  logic [15:0] last_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check_eq({tag, "_rsp_err"},   bus.rsp_err,   0);
    check_eq({tag, "_busy"},      bus.busy,      0);
    check_eq({tag, "_wren"},      bus.data_wren, 0);
    check_eq({tag, "_rden"},      bus.data_rden, 0);
    check_eq({tag, "_addr_in"},   bus.addr_in,   0);
    check_eq({tag, "_addr_out"},  bus.addr_out,  0);
    check_eq({tag, "_data_in"},   bus.data_in,   0);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [15:0] d, input bit clr);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = a; bus.cmd_wdata = d;
    @(negedge clk);
    check_eq("wr_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (clr) bus.clear_valid = 1'b1;
    if (clr) written = '0;
    written[a]   = 1'b1;
    model_mem[a] = d;
    last_waddr   = a;
    last_wdata   = d;
    @(negedge clk);
    check_eq("wr_wren",    bus.data_wren, 1);
    check_eq("wr_rden",    bus.data_rden, 0);
    check_eq("wr_addr_in", bus.addr_in,   a);
    check_eq("wr_data_in", bus.data_in,   d);
    check_eq("wr_busy",    bus.busy,      1);
    check_eq("wr_rdy_low", bus.cmd_ready, 0);
    @(posedge clk); #1;
    bus.clear_valid = 1'b0;
    @(negedge clk);
    check_eq("wr_wren_off", bus.data_wren, 0);
    check_eq("wr_rdy_back", bus.cmd_ready, 1);
    check_eq("wr_idle",     bus.busy,      0);
  endtask

  task automatic do_read(input logic [4:0] a, input bit hold, input bit clr);
    int   cnt;
    bit   seen;
    exp_t ex;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = a;
    bus.rsp_ready = !hold;
    @(negedge clk);
    check_eq("rd_ready", bus.cmd_ready, 1);
    sb_q.push_back('{d: model_mem[a], e: ~written[a]});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (clr) begin
      bus.clear_valid = 1'b1;
      written = '0;
    end
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      check_eq("rd_rden", bus.data_rden, (cnt == 1) ? 1 : 0);
      check_eq("rd_wren", bus.data_wren, 0);
      if (cnt == 1) begin
        check_eq("rd_addr_out",  bus.addr_out, a);
        check_eq("rd_addr_hold", bus.addr_in,  last_waddr);
        check_eq("rd_data_hold", bus.data_in,  last_wdata);
        @(posedge clk); #1;
        bus.clear_valid = 1'b0;
      end
      if (bus.rsp_valid) begin
        seen = 1;
        check_eq("rd_latency", cnt, 3);
      end
    end
    if (!seen) begin
      check_eq("rd_timeout", 0, 1);
    end else begin
      if (hold) begin
        repeat (10) begin
          @(negedge clk);
          check_eq("bp_valid", bus.rsp_valid, 1);
          check_eq("bp_rdata", bus.rsp_rdata, sb_q[0].d);
          check_eq("bp_err",   bus.rsp_err,   sb_q[0].e);
          check_eq("bp_ready", bus.cmd_ready, 0);
          check_eq("bp_strb",  {bus.data_wren, bus.data_rden}, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
      end
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 0, 1);
      end else begin
        ex = sb_q.pop_front();
        check_eq("rsp_rdata", bus.rsp_rdata, ex.d);
        check_eq("rsp_err",   bus.rsp_err,   ex.e);
      end
      @(negedge clk);
      check_eq("rd_rdy_back", bus.cmd_ready, 1);
      check_eq("rd_vld_off",  bus.rsp_valid, 0);
    end
  endtask

  task automatic do_reset_mid_read(input logic [4:0] a);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = a;
    @(negedge clk);
    check_eq("mr_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_rden",    bus.data_rden, 1);
    check_eq("mr_rdy_rst", bus.cmd_ready, 0);
    @(posedge clk); #1;
    rst     = 1'b0;
    written = '0;
    @(negedge clk);
    check_reset_outputs("mr");
    check_eq("mr_rdy_after", bus.cmd_ready, 1);
    repeat (8) begin
      @(negedge clk);
      check_eq("mr_no_rsp", bus.rsp_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.rsp_ready   = 1'b1;
    bus.clear_valid = 1'b0;
    written         = '0;
    last_waddr      = '0;
    last_wdata      = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = 16'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    check_eq("rst_cmd_ready", bus.cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", bus.cmd_ready, 1);
    check_eq("post_rst_busy",  bus.busy,      0);

    // Basic write and read-back.
    do_write(5'd0, 16'd32, 0);
    do_read(5'd0, 0, 0);

    // Top of the address range, in-order responses.
    do_write(5'd30, 16'd100, 0);
    do_write(5'd31, 16'd200, 0);
    do_read(5'd30, 0, 0);
    do_read(5'd31, 0, 0);

    // Never-written location.
    do_read(5'd5, 0, 0);

    // Clear pulse while idle.
    @(posedge clk); #1 bus.clear_valid = 1'b1;
    @(posedge clk); #1 bus.clear_valid = 1'b0;
    written = '0;
    do_read(5'd0, 0, 0);

    // Response backpressure.
    do_read(5'd30, 1, 0);

    // Clear coinciding with a write in ISSUE: the write's bit survives.
    do_write(5'd7, 16'h0037, 1);
    do_read(5'd7, 0, 0);

    // Clear coinciding with a read in ISSUE: read sees the pre-clear bit.
    do_write(5'd9, 16'h0042, 0);
    do_read(5'd9, 0, 1);
    do_read(5'd9, 0, 0);

    // Reset in the read-strobe cycle: no response, bitmap wiped.
    do_write(5'd31, 16'hBEEF, 0);
    do_reset_mid_read(5'd31);
    last_waddr = '0;
    last_wdata = '0;
    do_read(5'd31, 0, 0);
    do_write(5'd31, 16'hCAFE, 0);
    do_read(5'd31, 0, 0);

    check_eq("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
